wca_agc_ctrl: RTL and testbench
===============================

WCA_AGC_CTRL -- requirements
Module: wca_agc_ctrl

Interface
REQ-001 SHALL have parameter GAIN_W, default 6, gain code width.
REQ-002 SHALL have parameter GAIN_MAX, default 63, highest legal gain code.
REQ-003 SHALL have parameter HYST, default 4, dead-band half-width in RSSI LSBs.
REQ-004 SHALL have parameter SETTLE_CYC, default 16, clocks ignored after each gain change.
REQ-005 SHALL have port: clock  in  1  single clock; all logic is on its rising edge.
REQ-006 SHALL have port: reset_n  in  1  reset, asynchronous, active-low.
REQ-007 SHALL have port: enable  in  1  loop enable.
REQ-008 SHALL have port: strobe  in  1  rssi sample valid, one clock per sample.
REQ-009 SHALL have port: rssi  in  8  unsigned signal-level estimate from the receive-path RSSI block.
REQ-010 SHALL have port: target  in  8  unsigned desired RSSI level.
REQ-011 SHALL have port: gain_init  in  GAIN_W  gain loaded at reset release.
REQ-012 SHALL have port: gain  out  GAIN_W  current gain code, sent to the front-end gain register.
REQ-013 SHALL have port: gain_valid  out  1  new gain pending; held until acknowledged.
REQ-014 SHALL have port: gain_ack  in  1  gain register writer accepted the gain.
REQ-015 SHALL have port: locked  out  1  loop is within the dead-band.
REQ-016 SHALL have port: sat  out  2  bit0 means gain==0; bit1 means gain==GAIN_MAX.

Function
REQ-017 SHALL implement states IDLE, MEASURE, REQUEST, SETTLE.
REQ-018 IDLE SHALL move to MEASURE on enable=1 and clear the accumulator and sample count.
REQ-019 MEASURE SHALL add rssi to a 10-bit sum on every strobe; after the 4th strobe the average is sum[9:2], then the sum and count clear.
REQ-020 Error SHALL be the 9-bit signed value avg minus target.
REQ-021 If error > HYST, gain SHALL decrease by the step; if error < -HYST, gain SHALL increase by the step; results clamp to 0..GAIN_MAX.
REQ-022 Step SHALL be 1, except as widened by REQ-034.
REQ-023 If gain changes, the FSM SHALL go to REQUEST with gain_valid=1 on the next clock; otherwise it stays in MEASURE.
REQ-024 In REQUEST, gain and gain_valid SHALL be stable until a clock with gain_ack=1; then gain_valid=0, the state becomes SETTLE, and the settle counter loads SETTLE_CYC-1.
REQ-025 SETTLE SHALL count down to 0 and then enter MEASURE with a cleared accumulator; strobes during REQUEST or SETTLE are discarded.
REQ-026 locked SHALL assert after 4 consecutive in-band averages and SHALL deassert in the same clock as any out-of-band average.
REQ-027 When enable=0 in MEASURE or SETTLE, the FSM SHALL go to IDLE on the next clock and hold gain; in REQUEST it SHALL complete the handshake first; locked clears on entry to IDLE.
REQ-028 gain_ack SHALL be ignored when gain_valid=0.
REQ-029 A clamped step that leaves gain unchanged SHALL NOT raise gain_valid; sat SHALL reflect the gain register combinationally.

Reset
REQ-030 While reset_n=0, state SHALL be IDLE, gain=gain_init, gain_valid=0, locked=0, sum/count/settle counter=0.
REQ-031 Reset asserted mid-handshake SHALL drop gain_valid immediately and asynchronously.
REQ-032 gain_init SHALL be sampled only during reset.

Configuration
REQ-033 Macro WCA_AGC_COARSE_STEP_EN SHALL select the step rule.
REQ-034 With the macro defined, step SHALL be 4 when |error| >= 32, else 1; without it, step SHALL always be 1.

Structure
REQ-035 Package wca_agc_pkg SHALL hold the state enum, the sample count (4), the coarse threshold (32) and the coarse step (4).
REQ-036 The accumulator and sample counter SHALL be sub-module wca_agc_avg, which outputs an 8-bit average and a one-clock avg_valid.

Verification
REQ-037 Scenario: gain_init=20, target=100, four strobes of rssi=120 -> gain=19, gain_valid=1 until ack, then 16 settle clocks.
REQ-038 Scenario: rssi=102 and 98 alternating with target=100 for 16 strobes -> no gain_valid; locked=1 after the 4th average.
REQ-039 Scenario: gain=62, rssi=10, target=100, coarse macro defined -> gain=63 (clamped), sat=2'b10; next average -> no request.
REQ-040 Scenario: rssi=200, target=100 with strobes during REQUEST and SETTLE -> strobes ignored; first new average uses only post-settle samples.
REQ-041 Scenario: gain_ack held off 50 clocks, then enable=0 -> gain stable and valid throughout; IDLE entered after the ack.
REQ-042 Scenario: reset_n pulsed low while gain_valid=1 -> gain_valid=0 asynchronously; gain=gain_init.

Source files
------------

// File: rtl/wca_agc_pkg.sv
// wca_agc_pkg -- shared constants for the AGC control loop.
//   State encoding, samples per average, lock depth and the coarse-step
//   threshold/size used when WCA_AGC_COARSE_STEP_EN is defined.
package wca_agc_pkg;

  // FSM state encoding
  typedef logic [1:0] agc_state_t;
  localparam agc_state_t ST_IDLE    = 2'd0;
  localparam agc_state_t ST_MEASURE = 2'd1;
  localparam agc_state_t ST_REQUEST = 2'd2;
  localparam agc_state_t ST_SETTLE  = 2'd3;

  localparam int unsigned SAMPLE_CNT  = 4;   // strobes per average
  localparam int unsigned LOCK_AVGS   = 4;   // in-band averages before locked
  localparam int unsigned COARSE_THR  = 32;  // |error| at which coarse step applies
  localparam int unsigned COARSE_STEP = 4;   // coarse gain step

endpackage

// File: rtl/wca_agc_avg.sv
// wca_agc_avg -- four-sample RSSI accumulator.
//   clock       : rising-edge clock
//   reset_n     : async active-low reset
//   clr_i       : synchronous clear of sum and count (wins over strobe_i)
//   strobe_i    : one RSSI sample this clock
//   rssi_i      : 8-bit unsigned sample
//   avg_o       : sum of the last four samples divided by four
//   avg_valid_o : one-clock pulse, the clock after the fourth sample
module wca_agc_avg
  import wca_agc_pkg::*;
(
  input  logic       clock,
  input  logic       reset_n,
  input  logic       clr_i,
  input  logic       strobe_i,
  input  logic [7:0] rssi_i,
  output logic [7:0] avg_o,
  output logic       avg_valid_o
);

  logic [9:0] sum_q, sum_d, sum_nxt;
  logic [1:0] cnt_q, cnt_d;
  logic [7:0] avg_q, avg_d;
  logic       vld_q, vld_d;

  assign sum_nxt = sum_q + {2'b00, rssi_i};

  always_comb begin
    sum_d = sum_q;
    cnt_d = cnt_q;
    avg_d = avg_q;
    vld_d = 1'b0;
    if (clr_i) begin
      sum_d = '0;
      cnt_d = '0;
    end else if (strobe_i) begin
      if (cnt_q == 2'(SAMPLE_CNT - 1)) begin
        avg_d = sum_nxt[9:2];
        vld_d = 1'b1;
        sum_d = '0;
        cnt_d = '0;
      end else begin
        sum_d = sum_nxt;
        cnt_d = cnt_q + 2'd1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sum_q <= '0;
      cnt_q <= '0;
      avg_q <= '0;
      vld_q <= 1'b0;
    end else begin
      sum_q <= sum_d;
      cnt_q <= cnt_d;
      avg_q <= avg_d;
      vld_q <= vld_d;
    end
  end

  assign avg_o       = avg_q;
  assign avg_valid_o = vld_q;

endmodule

// File: rtl/wca_agc_ctrl.sv
// wca_agc_ctrl -- RSSI-driven automatic gain control loop.
//   Averages four RSSI samples, compares against target with a dead-band,
//   steps the gain code, hands it to the front-end with a valid/ack
//   handshake and waits SETTLE_CYC clocks before measuring again.
//   Optional macro WCA_AGC_COARSE_STEP_EN: step of 4 when |error| >= 32.
// Ports:
//   clock, reset_n      : rising-edge clock, async active-low reset
//   enable              : loop enable
//   strobe, rssi        : RSSI sample valid / value
//   target              : desired RSSI level
//   gain_init           : gain loaded while in reset
//   gain, gain_valid    : gain code and pending flag (held until gain_ack)
//   gain_ack            : gain register writer accepted the gain
//   locked              : four consecutive in-band averages seen
//   sat                 : {gain==GAIN_MAX, gain==0}
module wca_agc_ctrl
  import wca_agc_pkg::*;
#(
  parameter int GAIN_W     = 6,
  parameter int GAIN_MAX   = 63,
  parameter int HYST       = 4,
  parameter int SETTLE_CYC = 16
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              enable,
  input  logic              strobe,
  input  logic [7:0]        rssi,
  input  logic [7:0]        target,
  input  logic [GAIN_W-1:0] gain_init,
  output logic [GAIN_W-1:0] gain,
  output logic              gain_valid,
  input  logic              gain_ack,
  output logic              locked,
  output logic [1:0]        sat
);

  localparam int CNT_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam int GW1   = GAIN_W + 1;
  localparam logic signed [8:0] HYST_P = $signed(9'(HYST));
  localparam logic signed [8:0] HYST_N = -HYST_P;
  localparam logic [GW1-1:0]    GMAX   = GW1'(GAIN_MAX);

  agc_state_t        state_q, state_d;
  logic [GAIN_W-1:0] gain_q, gain_d, gain_new;
  logic              gv_q, gv_d;
  logic              locked_q, locked_d;
  logic [2:0]        lock_cnt_q, lock_cnt_d;
  logic [CNT_W-1:0]  settle_q, settle_d;

  logic [7:0]        avg;
  logic              avg_valid;
  logic signed [8:0] err;
  logic              err_hi, err_lo;
  logic [GW1-1:0]    step, g_ext, g_inc, g_dec;

  // Accumulator runs only in MEASURE; any other state holds it clear,
  // which also discards strobes during REQUEST and SETTLE.
  wca_agc_avg u_avg (
    .clock       (clock),
    .reset_n     (reset_n),
    .clr_i       (state_q != ST_MEASURE),
    .strobe_i    (strobe),
    .rssi_i      (rssi),
    .avg_o       (avg),
    .avg_valid_o (avg_valid)
  );

  assign err    = $signed({1'b0, avg}) - $signed({1'b0, target});
  assign err_hi = (err > HYST_P);
  assign err_lo = (err < HYST_N);

`ifdef WCA_AGC_COARSE_STEP_EN
  localparam logic signed [8:0] THR_P = $signed(9'(COARSE_THR));
  localparam logic signed [8:0] THR_N = -THR_P;
  assign step = ((err >= THR_P) || (err <= THR_N)) ? GW1'(COARSE_STEP) : GW1'(1);
`else
  assign step = GW1'(1);
`endif

  // Clamped up/down candidates, computed one bit wider to catch overflow
  assign g_ext = {1'b0, gain_q};
  assign g_inc = ((g_ext + step) > GMAX) ? GMAX : (g_ext + step);
  assign g_dec = (g_ext >= step) ? (g_ext - step) : '0;

  always_comb begin
    gain_new = gain_q;
    if (err_hi)      gain_new = g_dec[GAIN_W-1:0];
    else if (err_lo) gain_new = g_inc[GAIN_W-1:0];
  end

  always_comb begin
    state_d    = state_q;
    gain_d     = gain_q;
    gv_d       = gv_q;
    locked_d   = locked_q;
    lock_cnt_d = lock_cnt_q;
    settle_d   = settle_q;
    case (state_q)
      ST_IDLE: begin
        if (enable) state_d = ST_MEASURE;
      end
      ST_MEASURE: begin
        if (!enable) begin
          state_d    = ST_IDLE;
          locked_d   = 1'b0;
          lock_cnt_d = '0;
        end else if (avg_valid) begin
          if (!err_hi && !err_lo) begin
            if (lock_cnt_q < 3'(LOCK_AVGS)) lock_cnt_d = lock_cnt_q + 3'd1;
            locked_d = (lock_cnt_q >= 3'(LOCK_AVGS - 1));
          end else begin
            lock_cnt_d = '0;
            locked_d   = 1'b0;
          end
          // A step clamped to no change raises no request
          if (gain_new != gain_q) begin
            gain_d  = gain_new;
            gv_d    = 1'b1;
            state_d = ST_REQUEST;
          end
        end
      end
      ST_REQUEST: begin
        // Handshake completes even with enable low; then straight to IDLE
        if (gain_ack) begin
          gv_d = 1'b0;
          if (enable) begin
            state_d  = ST_SETTLE;
            settle_d = CNT_W'(SETTLE_CYC - 1);
          end else begin
            state_d    = ST_IDLE;
            locked_d   = 1'b0;
            lock_cnt_d = '0;
          end
        end
      end
      default: begin  // ST_SETTLE
        if (!enable) begin
          state_d    = ST_IDLE;
          locked_d   = 1'b0;
          lock_cnt_d = '0;
        end else if (settle_q == '0) begin
          state_d = ST_MEASURE;
        end else begin
          settle_d = settle_q - CNT_W'(1);
        end
      end
    endcase
  end

  // gain_init is only observed through the async reset load
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      gain_q     <= gain_init;
      gv_q       <= 1'b0;
      locked_q   <= 1'b0;
      lock_cnt_q <= '0;
      settle_q   <= '0;
    end else begin
      state_q    <= state_d;
      gain_q     <= gain_d;
      gv_q       <= gv_d;
      locked_q   <= locked_d;
      lock_cnt_q <= lock_cnt_d;
      settle_q   <= settle_d;
    end
  end

  assign gain       = gain_q;
  assign gain_valid = gv_q;
  assign locked     = locked_q;
  assign sat        = {gain_q == GAIN_W'(GAIN_MAX), gain_q == '0};

endmodule

// File: tb/tb_wca_agc_ctrl.sv
// tb_wca_agc_ctrl -- directed scoreboard bench for wca_agc_ctrl.
//   Stimulus pushes the hand-computed gain of each expected request into a
//   queue; a negedge monitor pops and compares on every rising gain_valid
//   and checks gain stays put while gain_valid is held.
module tb_wca_agc_ctrl;

`ifdef WCA_AGC_COARSE_STEP_EN
  localparam int BIG = 4;  // step for |error| >= 32
`else
  localparam int BIG = 1;
`endif

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       enable = 1'b0;
  logic       strobe = 1'b0;
  logic       gain_ack = 1'b0;
  logic [7:0] rssi = 8'd0;
  logic [7:0] target = 8'd100;
  logic [5:0] gain_init = 6'd0;
  logic [5:0] gain;
  logic       gain_valid;
  logic       locked;
  logic [1:0] sat;

  int n_chk = 0;
  int n_fail = 0;
  int exp_q[$];
  logic       gv_prev = 1'b0;
  logic [5:0] held = 6'd0;

  wca_agc_ctrl dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .enable     (enable),
    .strobe     (strobe),
    .rssi       (rssi),
    .target     (target),
    .gain_init  (gain_init),
    .gain       (gain),
    .gain_valid (gain_valid),
    .gain_ack   (gain_ack),
    .locked     (locked),
    .sat        (sat)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: scoreboard pop on each new request, stability while pending
  always @(negedge clock) begin
    int e;
    if (!reset_n) begin
      gv_prev <= 1'b0;
    end else begin
      if (gain_valid && !gv_prev) begin
        if (exp_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_req: got gain %0d with no request expected", gain);
        end else begin
          e = exp_q.pop_front();
          chk("req_gain", int'(gain), e);
        end
        held <= gain;
      end else if (gain_valid && gv_prev) begin
        chk("gain_stable", int'(gain), int'(held));
      end
      gv_prev <= gain_valid;
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic send(input int r, input int n);
    strobe = 1'b1;
    rssi   = 8'(r);
    tick(n);
    strobe = 1'b0;
  endtask

  task automatic send_alt(input int n);
    for (int i = 0; i < n; i++) begin
      strobe = 1'b1;
      rssi   = (i % 2 == 0) ? 8'd102 : 8'd98;
      tick(1);
    end
    strobe = 1'b0;
  endtask

  task automatic wait_gv(input int bound, output int cyc);
    cyc = 0;
    while (!gain_valid && cyc < bound) begin
      tick(1);
      cyc++;
    end
    if (!gain_valid) begin
      n_chk++;
      n_fail++;
      $display("FAIL wait_gv: no gain_valid after %0d clocks", bound);
    end
  endtask

  task automatic ack();
    gain_ack = 1'b1;
    tick(1);
    gain_ack = 1'b0;
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    // Reset state
    gain_init = 6'd20;
    tick(3);
    chk("rst_gain", int'(gain), 20);
    chk("rst_gv", int'(gain_valid), 0);
    chk("rst_locked", int'(locked), 0);
    chk("rst_sat", int'(sat), 0);
    reset_n = 1'b1;
    tick(1);
    enable = 1'b1;
    target = 8'd100;
    tick(1);

    // Avg 120 vs 100: one step down, request the clock after the average
    exp_q.push_back(19);
    send(120, 4);
    wait_gv(10, cyc);
    chk("req_latency", cyc, 1);
    tick(3);
    ack();
    chk("ack_drop_gv", int'(gain_valid), 0);

    // Continuous strobes through SETTLE: 16 settle clocks + 4 fresh samples
    strobe = 1'b1;
    rssi   = 8'd200;
    exp_q.push_back(19 - BIG);
    wait_gv(40, cyc);
    chk("settle_gap1", cyc, 21);
    exp_q.push_back(19 - 2 * BIG);
    tick(3);
    ack();
    wait_gv(40, cyc);
    chk("settle_gap2", cyc, 21);
    strobe = 1'b0;
    ack();
    tick(20);

    // Lock: in-band averages, dead-band edges, then an out-of-band average
    send_alt(12);
    tick(2);
    chk("lock_after3", int'(locked), 0);
    send_alt(4);
    tick(2);
    chk("lock_after4", int'(locked), 1);
    send(104, 4);
    tick(2);
    chk("lock_hyst_hi", int'(locked), 1);
    send(96, 4);
    tick(2);
    chk("lock_hyst_lo", int'(locked), 1);
    exp_q.push_back(18 - 2 * BIG);
    send(105, 4);
    wait_gv(10, cyc);
    chk("unlock_same_clk", int'(locked), 0);
    tick(2);
    ack();
    tick(20);

    // Ack held off, enable dropped while pending
    exp_q.push_back(17 - 2 * BIG);
    send(120, 4);
    wait_gv(10, cyc);
    tick(50);
    enable = 1'b0;
    tick(5);
    chk("hold_gv", int'(gain_valid), 1);
    chk("hold_gain", int'(gain), 17 - 2 * BIG);
    ack();
    chk("idle_gv", int'(gain_valid), 0);
    send(10, 4);
    tick(4);
    chk("idle_no_req", int'(gain_valid), 0);
    chk("idle_gain", int'(gain), 17 - 2 * BIG);

    // Top clamp
    reset_n   = 1'b0;
    gain_init = 6'd62;
    tick(2);
    chk("rst62_gain", int'(gain), 62);
    chk("rst62_sat", int'(sat), 0);
    reset_n = 1'b1;
    enable  = 1'b1;
    tick(1);
    exp_q.push_back(63);
    send(10, 4);
    wait_gv(10, cyc);
    chk("sat_max", int'(sat), 2);
    ack();
    tick(20);
    send(10, 4);
    tick(4);
    chk("clamp_max_no_req", int'(gain_valid), 0);
    chk("clamp_max_gain", int'(gain), 63);

    // Bottom clamp
    reset_n   = 1'b0;
    gain_init = 6'd0;
    tick(2);
    chk("sat_zero", int'(sat), 1);
    reset_n = 1'b1;
    tick(1);
    send(200, 4);
    tick(4);
    chk("clamp_min_no_req", int'(gain_valid), 0);
    chk("clamp_min_gain", int'(gain), 0);

    // Async reset mid-handshake
    exp_q.push_back(BIG);
    send(10, 4);
    wait_gv(10, cyc);
    @(negedge clock);
    #1;
    gain_init = 6'd33;
    reset_n   = 1'b0;
    #1;
    chk("async_rst_gv", int'(gain_valid), 0);
    chk("async_rst_gain", int'(gain), 33);
    chk("async_rst_locked", int'(locked), 0);
    tick(1);
    reset_n = 1'b1;
    tick(1);
    gain_init = 6'd5;
    tick(3);
    chk("init_only_in_reset", int'(gain), 33);

    chk("scoreboard_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
